// File: rtl/kmap_sweep_checker_if.sv
// kmap_sweep_checker_if: sweep request, DUT drive/sense and result bus of the sweep checker
interface kmap_sweep_checker_if #(
    parameter int N_IN = 3
) ();
    localparam int W = 2 ** N_IN;
    logic            start;
    logic [W-1:0]    expected;
    logic [N_IN-1:0] vec_out;
    logic            f_in;
    logic            busy;
    logic            done;
    logic [W-1:0]    table_out;
    logic [W-1:0]    mismatch_mask;
    logic            pass;
    logic [N_IN-1:0] first_fail_idx;
    logic            first_fail_valid;
    modport master (
        output start, expected, f_in,
        input  vec_out, busy, done, table_out, mismatch_mask, pass, first_fail_idx, first_fail_valid
    );
    modport slave (
        input  start, expected, f_in,
        output vec_out, busy, done, table_out, mismatch_mask, pass, first_fail_idx, first_fail_valid
    );
endinterface

// File: rtl/kmap_sweep_checker.sv
// kmap_sweep_checker: sweeps all input codes of a combinational block, captures its truth table and checks it (KMAP_SWEEP_GRAY_EN selects Gray sweep order)
module kmap_sweep_checker #(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input logic                clk,
    input logic                rst,
    kmap_sweep_checker_if.slave bus
);
    localparam int W  = 2 ** N_IN;
    localparam int CW = $clog2(SETTLE_CYCLES + 2);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t          state;
    logic [N_IN-1:0] idx;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    exp_q;
    logic [W-1:0]    tbl_nxt;
    logic [W-1:0]    mm_nxt;
    logic [N_IN-1:0] ff_nxt;

    function automatic logic [N_IN-1:0] code(input logic [N_IN-1:0] i);
`ifdef KMAP_SWEEP_GRAY_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    // table including the sample taken this cycle, its mismatch against the latched expectation and lowest failing minterm
    always_comb begin
        tbl_nxt = bus.table_out;
        tbl_nxt[code(idx)] = bus.f_in;
        mm_nxt = tbl_nxt ^ exp_q;
        ff_nxt = '0;
        for (int k = W - 1; k >= 0; k--)
            if (mm_nxt[k]) ff_nxt = N_IN'(k);
    end

    // sweep FSM with registered drive and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            idx                  <= '0;
            cnt                  <= '0;
            exp_q                <= '0;
            bus.vec_out          <= '0;
            bus.busy             <= 1'b0;
            bus.done             <= 1'b0;
            bus.table_out        <= '0;
            bus.mismatch_mask    <= '0;
            bus.pass             <= 1'b0;
            bus.first_fail_idx   <= '0;
            bus.first_fail_valid <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    state                <= SETTLE;
                    exp_q                <= bus.expected;
                    idx                  <= '0;
                    bus.vec_out          <= code('0);
                    cnt                  <= CW'(SETTLE_CYCLES);
                    bus.busy             <= 1'b1;
                    bus.table_out        <= '0;
                    bus.mismatch_mask    <= '0;
                    bus.pass             <= 1'b0;
                    bus.first_fail_idx   <= '0;
                    bus.first_fail_valid <= 1'b0;
                end
                SETTLE: if (cnt == '0) state <= SAMPLE;
                        else cnt <= cnt - 1'b1;
                SAMPLE: begin
                    bus.table_out <= tbl_nxt;
                    if (&idx) begin
                        state                <= DONE;
                        bus.busy             <= 1'b0;
                        bus.done             <= 1'b1;
                        bus.mismatch_mask    <= mm_nxt;
                        bus.pass             <= ~|mm_nxt;
                        bus.first_fail_idx   <= ff_nxt;
                        bus.first_fail_valid <= |mm_nxt;
                    end else begin
                        state       <= SETTLE;
                        idx         <= idx + 1'b1;
                        bus.vec_out <= code(idx + 1'b1);
                        cnt         <= CW'(SETTLE_CYCLES);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kmap_sweep_checker.sv
// tb_kmap_sweep_checker: randomized and directed checks of the sweep checker against a truth-table model
module tb_kmap_sweep_checker;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] fmask = 8'h00;
    int         tests = 0;
    int         failed = 0;
    int         order[8];

    kmap_sweep_checker_if #(.N_IN(3)) bus ();
    kmap_sweep_checker dut (.clk(clk), .rst(rst), .bus(bus));

    assign bus.f_in = fmask[bus.vec_out];

    always #5 clk = ~clk;

    function automatic logic [7:0] kmap_model();
        logic [7:0] t;
        for (int i = 0; i < 8; i++) begin
            logic a, b, c;
            a = i[2]; b = i[1]; c = i[0];
            t[i] = (~a & b) | (a & c);
        end
        return t;
    endfunction

    function automatic int lowest_set(input logic [7:0] m);
        for (int i = 0; i < 8; i++) if (m[i]) return i;
        return 0;
    endfunction

    task automatic check_idle_zero(input string name);
        tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.vec_out !== 3'd0 || bus.table_out !== 8'h00 ||
            bus.mismatch_mask !== 8'h00 || bus.pass !== 1'b0 || bus.first_fail_idx !== 3'd0 || bus.first_fail_valid !== 1'b0) begin
            failed++;
            $display("FAIL %s: busy=%b done=%b vec=%0d tbl=%h mm=%h pass=%b ffi=%0d ffv=%b, want all zero",
                     name, bus.busy, bus.done, bus.vec_out, bus.table_out, bus.mismatch_mask, bus.pass, bus.first_fail_idx, bus.first_fail_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.expected = 8'h00;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_sweep(input string name, input logic [7:0] fm, input logic [7:0] ex,
                             input int chg_cyc, input logic [7:0] chg_val);
        int cyc, lat;
        logic [7:0] mm;
        fmask = fm;
        mm = fm ^ ex;
        @(negedge clk);
        bus.start = 1'b1;
        bus.expected = ex;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        lat = -1;
        while (cyc <= 200 && lat < 0) begin
            if (cyc == chg_cyc) bus.expected = chg_val;
            if (bus.done === 1'b1) lat = cyc;
            else begin
                if (cyc <= 32) begin
                    tests++;
                    if (bus.vec_out !== 3'(order[(cyc - 1) / 4]) || bus.busy !== 1'b1) begin
                        failed++;
                        $display("FAIL %s vec cyc %0d: vec=%0d busy=%b want vec=%0d busy=1",
                                 name, cyc, bus.vec_out, bus.busy, order[(cyc - 1) / 4]);
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        tests++;
        if (lat != 33) begin
            failed++;
            $display("FAIL %s latency: got %0d want 33", name, lat);
        end
        tests++;
        if (bus.busy !== 1'b0 || bus.table_out !== fm || bus.mismatch_mask !== mm || bus.pass !== (mm == 8'h00) ||
            bus.first_fail_valid !== (mm != 8'h00) || (mm != 8'h00 && bus.first_fail_idx !== 3'(lowest_set(mm)))) begin
            failed++;
            $display("FAIL %s result: busy=%b tbl=%h mm=%h pass=%b ffi=%0d ffv=%b want tbl=%h mm=%h pass=%b ffi=%0d ffv=%b",
                     name, bus.busy, bus.table_out, bus.mismatch_mask, bus.pass, bus.first_fail_idx, bus.first_fail_valid,
                     fm, mm, mm == 8'h00, lowest_set(mm), mm != 8'h00);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.table_out !== fm || bus.mismatch_mask !== mm || bus.vec_out !== 3'(order[7])) begin
            failed++;
            $display("FAIL %s hold: done=%b busy=%b tbl=%h mm=%h vec=%0d want done=0 busy=0 tbl=%h mm=%h vec=%0d",
                     name, bus.done, bus.busy, bus.table_out, bus.mismatch_mask, bus.vec_out, fm, mm, order[7]);
        end
    endtask

    task automatic test_model();
        run_sweep("model_ac", kmap_model(), 8'hAC, 0, 8'h00);
        run_sweep("model_ad", kmap_model(), 8'hAD, 0, 8'h00);
        run_sweep("model_2c", kmap_model(), 8'h2C, 0, 8'h00);
    endtask

    task automatic test_expected_latch();
        run_sweep("exp_change", 8'hFF, 8'hFF, 5, 8'h00);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            logic [7:0] fm, ex;
            fm = 8'($urandom);
            ex = ($urandom_range(0, 2) == 0) ? fm : 8'($urandom);
            run_sweep($sformatf("random%0d", n), fm, ex, 0, 8'h00);
        end
    endtask

    task automatic test_back_to_back();
        int done_cycles[$];
        int low_cycles[$];
        fmask = kmap_model();
        bus.expected = 8'hAC;
        @(negedge clk);
        bus.start = 1'b1;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_cycles.push_back(cyc);
            if (bus.busy !== 1'b1) low_cycles.push_back(cyc);
        end
        bus.start = 1'b0;
        tests++;
        if (done_cycles.size() != 2 || done_cycles[0] != 33 || done_cycles[1] != 67) begin
            failed++;
            $display("FAIL back_to_back done: got %p want '{33, 67}", done_cycles);
        end
        tests++;
        if (low_cycles.size() != 4 || low_cycles[0] != 33 || low_cycles[1] != 34 || low_cycles[2] != 67 || low_cycles[3] != 68) begin
            failed++;
            $display("FAIL back_to_back busy_low: got %p want '{33, 34, 67, 68}", low_cycles);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_zero("back_to_back reset");
    endtask

    task automatic test_reset_mid_sweep();
        int dones;
        fmask = 8'hFF;
        @(negedge clk);
        bus.start = 1'b1;
        bus.expected = 8'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        for (int cyc = 2; cyc <= 10; cyc++) @(negedge clk);
        tests++;
        if (bus.busy !== 1'b1 || bus.table_out === 8'h00) begin
            failed++;
            $display("FAIL mid_reset pre: busy=%b tbl=%h want busy=1 tbl nonzero", bus.busy, bus.table_out);
        end
        rst = 1'b1;
        @(negedge clk);
        check_idle_zero("mid_reset cyc11");
        rst = 1'b0;
        dones = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
        end
        tests++;
        if (dones != 0) begin
            failed++;
            $display("FAIL mid_reset after: got %0d done/busy cycles want 0", dones);
        end
    endtask

    initial begin
`ifdef KMAP_SWEEP_GRAY_EN
        order = '{0, 1, 3, 2, 6, 7, 5, 4};
`else
        order = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
        test_reset();
        test_model();
        test_expected_latch();
        test_random();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/kmap_sweep_checker.md
Name: kmap_sweep_checker

Overview:
- Self-checking sweep stage wrapped around a small combinational Karnaugh-map block (3-input a/b/c -> out).
- Upstream role: drives every input combination onto the block's inputs.
- Downstream role: samples the block's output per combination, assembles the full truth table and compares it to an expected minterm mask.
- Gives the lab flow a synthesizable, clocked pass/fail check in place of a monitor-only bench.

Parameters:
- N_IN, 3, number of function inputs; truth table width W = 2**N_IN (supported 1..5).
- SETTLE_CYCLES, 2, extra cycles each vector is held before sampling; 0 is legal (vector held 1 cycle).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  sweep request; honoured only in IDLE
- expected  input  W  expected truth table; bit i = f(minterm i), minterm i = {a,b,c} = i
- vec_out  output  N_IN  drives DUT inputs; vec_out[N_IN-1] = a (MSB), vec_out[0] = c
- f_in  input  1  DUT output (out)
- busy  output  1  high while sweeping
- done  output  1  one-cycle pulse when results become valid
- table_out  output  W  captured truth table
- mismatch_mask  output  W  table_out XOR latched expected
- pass  output  1  mismatch_mask == 0; valid from done
- first_fail_idx  output  N_IN  lowest set bit index of mismatch_mask
- first_fail_valid  output  1  mismatch_mask != 0

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; internal index, settle counter and latched expected cleared.
- States:
  - IDLE: start=1 -> SETTLE. On the same edge: expected latched, idx=0, vec_out=code(0), cnt=SETTLE_CYCLES, table_out cleared, result outputs cleared.
  - SETTLE: if cnt==0 -> SAMPLE, else cnt--.
  - SAMPLE: table_out[code(idx)] <= f_in.
    - If idx==W-1 -> DONE.
    - Else idx++, vec_out<=code(idx+1), cnt<=SETTLE_CYCLES, -> SETTLE.
  - DONE: done=1 for exactly this cycle; mismatch_mask, pass, first_fail_* registered on entry; -> IDLE.
- Each vector is held stable for exactly SETTLE_CYCLES+2 cycles. f_in is sampled at the end of the last of these.
- Total latency: start edge to done-high cycle = W*(SETTLE_CYCLES+2)+1 cycles. Defaults give 33.
- busy=1 in SETTLE and SAMPLE; 0 in IDLE and DONE.
- start is ignored outside IDLE. Start held high continuously re-arms on the first IDLE cycle after DONE.
- vec_out holds its last vector after the sweep until the next start.
- Results hold until the next start or reset.
- expected is used only as latched at start; changes during a sweep have no effect.
- code(i)=i in default build.
- rst mid-sweep: next cycle is IDLE, all outputs 0, no done pulse.
- rst and start together: rst wins.

Optional Feature:
- Macro: KMAP_SWEEP_GRAY_EN.
- Defined: code(i) = i ^ (i>>1). vec_out follows Gray order (N_IN=3: 0,1,3,2,6,7,5,4), so only one input toggles per step. Capture is still indexed by the minterm value, so table_out is identical to the binary build.
- Undefined: binary order 0..W-1.
- Latency is identical in both builds.

Test Plan:
- Model f = (~a&b)|(a&c), expected=8'hAC, defaults, start pulse at edge 0:
  - done high exactly at cycle 33.
  - table_out=8'hAC, mismatch_mask=8'h00, pass=1, first_fail_valid=0.
  - vec_out steps 0..7, each held 4 cycles.
- Same model, expected=8'hAD:
  - mismatch_mask=8'h01, pass=0, first_fail_idx=0, first_fail_valid=1.
- Same model, expected=8'h2C:
  - mismatch_mask=8'h80, first_fail_idx=7.
- start held high for 80 cycles:
  - done pulses at cycles 33 and 67 only; busy low exactly one cycle (DONE) plus IDLE between sweeps.
- rst asserted at cycle 10 of a sweep:
  - cycle 11: busy=0, vec_out=0, table_out=0, pass=0.
  - no done pulse follows.
- f_in tied 1, expected=8'hFF at start, changed to 8'h00 at cycle 5:
  - pass=1, table_out=8'hFF.
- KMAP_SWEEP_GRAY_EN defined, model as in the first scenario:
  - vec_out sequence 0,1,3,2,6,7,5,4.
  - table_out=8'hAC, done at cycle 33.
